// File: rtl/scs8hd_rep3_tx.sv
// Rep-3 serial transmitter: frames a word as start/data/stop bits, each sent as
// three identical chips of HOLD cycles, LSB-first, from a registered line driver.
module scs8hd_rep3_tx #(
  parameter int DATA_W = 8,
  parameter int HOLD   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TXD,
  output logic              BUSY,
  output logic              DONE
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        r_state;
  logic [HW-1:0]     r_hold;
  logic [1:0]        r_chip;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_sh;
  logic              r_txd;

  logic              w_hold_end;
  logic              w_grp_end;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_sh_next;

  assign w_hold_end = (r_hold == HW'(HOLD - 1));
  assign w_grp_end  = w_hold_end && (r_chip == 2'd2);
  assign w_last_bit = (r_bit == BW'(DATA_W - 1));
  assign w_sh_next  = r_sh >> 1;

  assign DIN_READY = (r_state == S_IDLE);
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_STOP) && w_grp_end;
  assign TXD       = r_txd;

  // TXD is loaded with the value of the state being entered, so it changes on
  // the same edge as the state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (DIN_VALID) begin
          r_sh    <= DIN;
          r_state <= S_START;
          r_txd   <= 1'b0;
        end
        S_START: if (w_grp_end) begin
          r_state <= S_DATA;
          r_txd   <= r_sh[0];
        end
        S_DATA: if (w_grp_end) begin
          r_sh <= w_sh_next;
          if (w_last_bit) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end else begin
            r_txd <= w_sh_next[0];
          end
        end
        S_STOP: if (w_grp_end) begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Counters idle at zero and return there when the stop group wraps.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hold <= '0;
      r_chip <= '0;
      r_bit  <= '0;
    end else if (r_state != S_IDLE) begin
      r_hold <= w_hold_end ? '0 : r_hold + 1'b1;
      if (w_hold_end)
        r_chip <= (r_chip == 2'd2) ? 2'd0 : r_chip + 2'd1;
      if (r_state == S_DATA && w_grp_end)
        r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
    end
  end
endmodule

// File: tb/tb_scs8hd_rep3_tx.sv
// Scoreboard bench for scs8hd_rep3_tx in two configurations (8-bit/HOLD=1 and
// 4-bit/HOLD=3): accepted words expand into per-cycle expected line values.
module tb_scs8hd_rep3_tx;
  logic clk;
  int   checks;
  int   failures;
  int   fin_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s got=%0h exp=%0h t=%0t", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int DW = (g == 0) ? 8 : 4;
    localparam int HD = (g == 0) ? 1 : 3;
    localparam int FL = 3 * HD * (DW + 2);
    localparam logic [7:0] W0 = (g == 0) ? 8'hA5 : 8'h06;

    typedef struct packed {
      logic txd;
      logic done;
    } exp_t;

    logic          rst, din_valid, din_ready, txd, busy, done;
    logic [DW-1:0] din;
    exp_t          q[$];
    int            m_rem;

    scs8hd_rep3_tx #(.DATA_W(DW), .HOLD(HD)) u_dut (
      .CLK(clk), .RESET(rst), .DIN(din), .DIN_VALID(din_valid),
      .DIN_READY(din_ready), .TXD(txd), .BUSY(busy), .DONE(done)
    );

    // Expected line: 0 for start, data LSB-first, 1 for stop; each bit lasts
    // 3*HOLD cycles, DONE only in the very last cycle of the frame.
    task automatic push_frame(input logic [DW-1:0] d);
      logic bv;
      exp_t e;
      for (int b = 0; b < DW + 2; b++) begin
        if (b == 0) bv = 1'b0;
        else if (b == DW + 1) bv = 1'b1;
        else bv = d[b-1];
        for (int c = 0; c < 3 * HD; c++) begin
          e.txd  = bv;
          e.done = (b == DW + 1) && (c == 3 * HD - 1);
          q.push_back(e);
        end
      end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d);
      @(negedge clk);
      #1;
      din_valid = v;
      din       = d;
      @(posedge clk);
      if (!rst && v && m_rem == 0) begin
        push_frame(d);
        m_rem = FL;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    endtask

    task automatic do_rst(input int n);
      @(negedge clk);
      din_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_txd", g, 32'(txd), 32'd1);
      chk("rst_ready", g, 32'(din_ready), 32'd1);
      chk("rst_busy", g, 32'(busy), 32'd0);
      chk("rst_done", g, 32'(done), 32'd0);
      q.delete();
      m_rem = 0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
    endtask

    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("txd", g, 32'(txd), 32'(e.txd));
          chk("done", g, 32'(done), 32'(e.done));
          chk("busy", g, 32'(busy), 32'd1);
          chk("ready", g, 32'(din_ready), 32'd0);
        end else begin
          chk("idle_txd", g, 32'(txd), 32'd1);
          chk("idle_done", g, 32'(done), 32'd0);
          chk("idle_busy", g, 32'(busy), 32'd0);
          chk("idle_ready", g, 32'(din_ready), 32'd1);
        end
      end
    end

    initial begin
      rst = 1'b1; din_valid = 1'b0; din = '0; m_rem = 0;
      #1;
      chk("por_txd", g, 32'(txd), 32'd1);
      chk("por_ready", g, 32'(din_ready), 32'd1);
      chk("por_busy", g, 32'(busy), 32'd0);
      chk("por_done", g, 32'(done), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) cyc(1'b0, '0);
      // single frame
      cyc(1'b1, W0[DW-1:0]);
      repeat (FL + 3) cyc(1'b0, '0);
      // valid pulse mid-frame must be ignored
      cyc(1'b1, W0[DW-1:0]);
      for (int i = 1; i < FL; i++) cyc(i == 10, DW'(8'h3C));
      repeat (5) cyc(1'b0, '0);
      // valid held high: zeros then ones, one idle cycle between frames
      for (int i = 0; i < 2 * (FL + 1); i++)
        cyc(1'b1, (i <= FL) ? {DW{1'b0}} : {DW{1'b1}});
      repeat (FL + 3) cyc(1'b0, '0);
      // abort mid-data, then a clean frame
      cyc(1'b1, W0[DW-1:0]);
      repeat (3 * HD * 2 + 1) cyc(1'b0, '0);
      do_rst(2);
      cyc(1'b1, DW'(8'h81));
      repeat (FL + 3) cyc(1'b0, '0);
      // random traffic with occasional resets
      for (int it = 0; it < 400; it++) begin
        if ($urandom_range(0, 49) == 0) do_rst(int'($urandom_range(1, 3)));
        else cyc($urandom_range(0, 3) == 0, DW'($urandom));
      end
      repeat (FL + 3) cyc(1'b0, '0);
      chk("drain", g, 32'(q.size()), 32'd0);
      fin_cnt++;
    end
  end

  initial begin
    checks = 0; failures = 0; fin_cnt = 0;
    for (int i = 0; i < 20000 && fin_cnt < 2; i++) @(posedge clk);
    if (fin_cnt < 2) begin
      failures++;
      $display("FAIL timeout fin_cnt=%0d exp=2", fin_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
